lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width (legal range 3..32).
REQ-002 SHALL provide parameter FIB_TAPS, default 8'hB8, Fibonacci tap mask (bit i set = state[i] feeds XOR).
REQ-003 SHALL provide parameter GAL_TAPS, default 8'h1D, Galois polynomial mask (low-order terms, x^WIDTH implied).
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load  input  1  capture seed and mode on next rising edge.
REQ-007 SHALL have port seed  input  WIDTH  initial vector captured by load.
REQ-008 SHALL have port mode  input  1  0 = Fibonacci, 1 = Galois; sampled only with load.
REQ-009 SHALL have port en  input  1  advance one LFSR step per rising edge when high.
REQ-010 SHALL have port state  output  WIDTH  current register contents.
REQ-011 SHALL have port bit_out  output  1  serial output, equal to state[WIDTH-1].
REQ-012 SHALL have port step_cnt  output  WIDTH  steps taken since last load/reset, wraps at 2^WIDTH.
REQ-013 SHALL have port period  output  WIDTH  last measured sequence length; 0 = none measured yet.
REQ-014 SHALL have port period_done  output  1  one-cycle pulse when state returns to captured seed.
REQ-015 SHALL have port lockup  output  1  one-cycle pulse when an all-zero state was detected and repaired.

Function
REQ-016 SHALL, on load, set state = seed, seed_q = seed, mode_q = mode, step_cnt = 0, period unchanged.
REQ-017 SHALL substitute 1 for a seed of all zeros at load, in both state and seed_q.
REQ-018 SHALL give load priority over en when both are high in the same cycle; no step is taken.
REQ-019 SHALL, in Fibonacci mode with en high, compute next = {state[WIDTH-2:0], ^(state & FIB_TAPS)}.
REQ-020 SHALL, in Galois mode with en high, compute next = {state[WIDTH-2:0],1'b0} XOR (state[WIDTH-1] ? GAL_TAPS : 0).
REQ-021 SHALL hold state, step_cnt and all registered outputs when en and load are both low.
REQ-022 SHALL increment step_cnt by 1 on every taken step, wrapping from 2^WIDTH-1 to 0.
REQ-023 SHALL, on a step whose next value equals seed_q, pulse period_done next cycle, set period = step_cnt+1, and clear step_cnt to 0.
REQ-024 SHALL keep period_done and lockup low in every cycle other than the pulse cycle.
REQ-025 SHALL, when en is high and state is all zeros, load seed_q instead of stepping, pulse lockup, and clear step_cnt.
REQ-026 SHALL not change mode_q while running; mode changes take effect only at the next load.
REQ-027 SHALL produce all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, while rst is high, asynchronously force state = 1, seed_q = 1, mode_q = 0, step_cnt = 0, period = 0, period_done = 0, lockup = 0.
REQ-029 SHALL resume normal operation on the first rising edge after rst deasserts; an assertion mid-sequence discards the measurement in progress.

Verification
REQ-030 SHALL pass: WIDTH=4, FIB_TAPS=4'hC, load seed 0001, then en high -> states 0010, 0100, 1001, 0011, ...; period_done on step 15 with period = 15.
REQ-031 SHALL pass: WIDTH=4, GAL_TAPS=4'h3, mode 1, load seed 0001 -> states 0010, 0100, 1000, 0011, ...; period = 15.
REQ-032 SHALL pass: load seed 0000 -> state = 0001 and seed_q = 0001; the sequence is identical to REQ-030.
REQ-033 SHALL pass: load and en high together with seed 1001 -> state = 1001 and step_cnt = 0; no step is taken.
REQ-034 SHALL pass: rst pulse between clock edges mid-sequence -> state = 1 and step_cnt = 0 immediately, period = 0, no period_done pulse.
REQ-035 SHALL pass: default WIDTH=8, Fibonacci mode, seed 8'h01, en held high -> period_done after 255 steps with period = 255; seeds 8'hFF, 8'h9D give the same period.

Source files
------------

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR with period measurement and all-zero lockup repair
module lfsr_gen #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] FIB_TAPS = 8'hB8,
   parameter logic [WIDTH-1:0] GAL_TAPS = 8'h1D
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             mode,
   input  logic             en,
   output logic [WIDTH-1:0] state,
   output logic             bit_out,
   output logic [WIDTH-1:0] step_cnt,
   output logic [WIDTH-1:0] period,
   output logic             period_done,
   output logic             lockup
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] seed_q;
   logic             mode_q;
   logic [WIDTH-1:0] seed_fix;
   logic [WIDTH-1:0] next_state;

   // An all-zero seed would freeze the register, so it is replaced by 1.
   always_comb begin
      seed_fix = (seed == '0) ? ONE : seed;
      if (mode_q)
         next_state = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_TAPS : '0);
      else
         next_state = {state[WIDTH-2:0], ^(state & FIB_TAPS)};
   end

   assign bit_out = state[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ONE;
         seed_q      <= ONE;
         mode_q      <= 1'b0;
         step_cnt    <= '0;
         period      <= '0;
         period_done <= 1'b0;
         lockup      <= 1'b0;
      end else begin
         period_done <= 1'b0;
         lockup      <= 1'b0;
         if (load) begin
            state    <= seed_fix;
            seed_q   <= seed_fix;
            mode_q   <= mode;
            step_cnt <= '0;
         end else if (en) begin
            if (state == '0) begin
               state    <= seed_q;
               lockup   <= 1'b1;
               step_cnt <= '0;
            end else begin
               state <= next_state;
               // Returning to the captured seed closes one full period.
               if (next_state == seed_q) begin
                  period_done <= 1'b1;
                  period      <= step_cnt + ONE;
                  step_cnt    <= '0;
               end else begin
                  step_cnt <= step_cnt + ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen against an arithmetic reference model
module tb_lfsr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        mode = 1'b0;
   logic        en = 1'b0;
   logic [31:0] seed = 32'd0;
   logic        armed = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [3:0] a_state, a_cnt, a_per;
   logic       a_bo, a_pd, a_lk;
   logic [7:0] b_state, b_cnt, b_per;
   logic       b_bo, b_pd, b_lk;
   logic [3:0] c_state, c_cnt, c_per;
   logic       c_bo, c_pd, c_lk;

   lfsr_gen #(.WIDTH(4), .FIB_TAPS(4'hC), .GAL_TAPS(4'h3)) ua (
      .clk(clk), .rst(rst), .load(load), .seed(seed[3:0]), .mode(mode), .en(en),
      .state(a_state), .bit_out(a_bo), .step_cnt(a_cnt), .period(a_per),
      .period_done(a_pd), .lockup(a_lk));

   lfsr_gen ub (
      .clk(clk), .rst(rst), .load(load), .seed(seed[7:0]), .mode(mode), .en(en),
      .state(b_state), .bit_out(b_bo), .step_cnt(b_cnt), .period(b_per),
      .period_done(b_pd), .lockup(b_lk));

   // Degenerate taps: the register shifts out to zero and must be repaired.
   lfsr_gen #(.WIDTH(4), .FIB_TAPS(4'h0), .GAL_TAPS(4'h0)) uc (
      .clk(clk), .rst(rst), .load(load), .seed(seed[3:0]), .mode(mode), .en(en),
      .state(c_state), .bit_out(c_bo), .step_cnt(c_cnt), .period(c_per),
      .period_done(c_pd), .lockup(c_lk));

   always #5 clk = ~clk;

   logic [31:0] d_st[3], d_cnt[3], d_per[3];
   logic        d_bo[3], d_pd[3], d_lk[3];
   assign d_st[0] = {28'd0, a_state};  assign d_cnt[0] = {28'd0, a_cnt};  assign d_per[0] = {28'd0, a_per};
   assign d_st[1] = {24'd0, b_state};  assign d_cnt[1] = {24'd0, b_cnt};  assign d_per[1] = {24'd0, b_per};
   assign d_st[2] = {28'd0, c_state};  assign d_cnt[2] = {28'd0, c_cnt};  assign d_per[2] = {28'd0, c_per};
   assign d_bo[0] = a_bo; assign d_pd[0] = a_pd; assign d_lk[0] = a_lk;
   assign d_bo[1] = b_bo; assign d_pd[1] = b_pd; assign d_lk[1] = b_lk;
   assign d_bo[2] = c_bo; assign d_pd[2] = c_pd; assign d_lk[2] = c_lk;

   int          wd[3]  = '{4, 8, 4};
   logic [31:0] fib[3] = '{32'hC, 32'hB8, 32'h0};
   logic [31:0] gal[3] = '{32'h3, 32'h1D, 32'h0};

   logic [31:0] ms[3], mseed[3], mcnt[3], mper[3];
   logic        mmode[3], mpd[3], mlk[3];

   function automatic logic [31:0] msk(int i);
      return (32'd1 << wd[i]) - 32'd1;
   endfunction

   function automatic logic [31:0] fix(int i, logic [31:0] s);
      logic [31:0] v;
      v = s & msk(i);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

   function automatic logic [31:0] nxt(int i, logic [31:0] s, logic md);
      logic msb;
      msb = s[wd[i]-1];
      if (md) return ((s << 1) & msk(i)) ^ (msb ? gal[i] : 32'd0);
      return ((s << 1) | 32'($countones(s & fib[i]) & 1)) & msk(i);
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            ms[i] <= 32'd1; mseed[i] <= 32'd1; mmode[i] <= 1'b0;
            mcnt[i] <= 32'd0; mper[i] <= 32'd0; mpd[i] <= 1'b0; mlk[i] <= 1'b0;
         end else begin
            mpd[i] <= 1'b0;
            mlk[i] <= 1'b0;
            if (load) begin
               ms[i] <= fix(i, seed); mseed[i] <= fix(i, seed);
               mmode[i] <= mode; mcnt[i] <= 32'd0;
            end else if (en) begin
               if (ms[i] == 32'd0) begin
                  ms[i] <= mseed[i]; mlk[i] <= 1'b1; mcnt[i] <= 32'd0;
               end else begin
                  ms[i] <= nxt(i, ms[i], mmode[i]);
                  if (nxt(i, ms[i], mmode[i]) == mseed[i]) begin
                     mpd[i] <= 1'b1;
                     mper[i] <= (mcnt[i] + 32'd1) & msk(i);
                     mcnt[i] <= 32'd0;
                  end else begin
                     mcnt[i] <= (mcnt[i] + 32'd1) & msk(i);
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("state%0d", i), d_st[i], ms[i]);
            check($sformatf("step_cnt%0d", i), d_cnt[i], mcnt[i]);
            check($sformatf("period%0d", i), d_per[i], mper[i]);
            check($sformatf("bit_out%0d", i), 32'(d_bo[i]), (ms[i] >> (wd[i] - 1)) & 32'd1);
            check($sformatf("period_done%0d", i), 32'(d_pd[i]), 32'(mpd[i]));
            check($sformatf("lockup%0d", i), 32'(d_lk[i]), 32'(mlk[i]));
         end
      end
   end

   task automatic run_seq(input logic md, input logic [3:0] sd, input logic [15:0] exp);
      bit found, lk_seen;
      mode = md; seed = {28'd0, sd}; load = 1'b1; en = 1'b0;
      @(negedge clk);
      load = 1'b0;
      check("load_state", {28'd0, a_state}, 32'd1);
      check("load_cnt", {28'd0, a_cnt}, 32'd0);
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("seq_m%0d_k%0d", md, k), {28'd0, a_state}, 32'((exp >> (12 - 4 * k)) & 16'hF));
         if (k == 3) check("c_zero_state", {28'd0, c_state}, 32'd0);
      end
      found = 0; lk_seen = 0;
      for (int cy = 5; cy <= 40 && !found; cy++) begin
         @(negedge clk);
         if (c_lk && !lk_seen) begin
            lk_seen = 1;
            check("lockup_step", cy, 5);
            check("lockup_state", {28'd0, c_state}, 32'd1);
         end
         if (a_pd) begin
            found = 1;
            check("period_step", cy, 15);
            check("period_val", {28'd0, a_per}, 32'd15);
         end
      end
      if (!found) check("period_timeout", 32'd0, 32'd1);
      if (!lk_seen) check("lockup_timeout", 32'd0, 32'd1);
      en = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] seeds8[3];
      bit found;
      seeds8 = '{8'h01, 8'hFF, 8'h9D};
      repeat (2) @(posedge clk);
      @(negedge clk);
      armed = 1'b1;
      check("rst_state", {28'd0, a_state}, 32'd1);
      check("rst_cnt", {28'd0, a_cnt}, 32'd0);
      check("rst_period", {28'd0, a_per}, 32'd0);
      rst = 1'b0;

      run_seq(1'b0, 4'h1, 16'h2493);
      run_seq(1'b1, 4'h1, 16'h2483);
      run_seq(1'b0, 4'h0, 16'h2493);

      mode = 1'b0; seed = 32'h9; load = 1'b1; en = 1'b1;
      @(negedge clk);
      check("load_en_state", {28'd0, a_state}, 32'h9);
      check("load_en_cnt", {28'd0, a_cnt}, 32'd0);
      load = 1'b0;
      repeat (3) @(negedge clk);
      check("period_kept", {28'd0, a_per}, 32'd15);
      #2 rst = 1'b1;
      #1;
      check("async_rst_state", {28'd0, a_state}, 32'd1);
      check("async_rst_cnt", {28'd0, a_cnt}, 32'd0);
      check("async_rst_period", {28'd0, a_per}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      for (int s = 0; s < 3; s++) begin
         en = 1'b0; mode = 1'b0; seed = {24'd0, seeds8[s]}; load = 1'b1;
         @(negedge clk);
         load = 1'b0; en = 1'b1;
         found = 0;
         for (int cy = 1; cy <= 300 && !found; cy++) begin
            @(negedge clk);
            if (b_pd) begin
               found = 1;
               check($sformatf("p8_step_%0h", seeds8[s]), cy, 255);
               check($sformatf("p8_val_%0h", seeds8[s]), {24'd0, b_per}, 32'd255);
            end
         end
         if (!found) check("p8_timeout", 32'd0, 32'd1);
      end

      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         load = ($urandom % 16) == 0;
         en   = ($urandom % 4) != 0;
         mode = 1'($urandom);
         seed = $urandom;
         if (($urandom % 200) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      @(negedge clk);
      armed = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
